// File: rtl/activation_feeder_if.sv
// Activation feeder bus: control handshake, BRAM read port and convolver stream.
// slave = feeder side, master = environment side (controller, BRAM, convolver).
interface activation_feeder_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic          stall;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_data;
  logic          conv_rst;
  logic [DW-1:0] activation;
  logic          ce_o;
  logic          end_conv;
  logic          busy;
  logic          done;

  modport slave (
    input  start, base_addr, stall, mem_data, end_conv,
    output mem_addr, mem_rd, conv_rst, activation, ce_o, busy, done
  );

  modport master (
    output start, base_addr, stall, mem_data, end_conv,
    input  mem_addr, mem_rd, conv_rst, activation, ce_o, busy, done
  );
endinterface

// File: rtl/activation_feeder.sv
// Activation feeder: streams an N x N map from a sync-read BRAM into a convolver.
// Optional feature macro FEEDER_STALL_CNT_EN adds the stall_cycles output counter.
module activation_feeder #(
  parameter int unsigned N     = 10,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned FLUSH = 2
) (
  input  logic                 clk,
  input  logic                 global_rst_n,
  activation_feeder_if.slave   fd_io
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int unsigned NN = N * N;
  localparam int unsigned CW = $clog2(NN + 1);
  localparam int unsigned FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  typedef enum logic [2:0] {StIdle, StClear, StStream, StFlush, StWaitEnd} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] rc_q, rc_d;        // reads issued
  logic [CW-1:0] pc_q, pc_d;        // words presented
  logic [FW-1:0] fc_q, fc_d;        // flush beats issued
  logic [AW-1:0] base_q, base_d;
  logic          rd_q, rd_d;        // read in flight: mem_data valid this cycle
  logic          hold_vld_q, hold_vld_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          done_q, done_d;

  logic          mem_rd, conv_rst, ce;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] act;

  // Next-state and stream datapath control
  always_comb begin
    state_d    = state_q;
    rc_d       = rc_q;
    pc_d       = pc_q;
    fc_d       = fc_q;
    base_d     = base_q;
    rd_d       = 1'b0;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    conv_rst   = 1'b0;
    ce         = 1'b0;
    act        = '0;
    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse is dropped
        if (fd_io.start && !done_q) begin
          base_d     = fd_io.base_addr;
          rc_d       = '0;
          pc_d       = '0;
          fc_d       = '0;
          hold_vld_d = 1'b0;
          state_d    = StClear;
        end
      end
      StClear: begin
        conv_rst = 1'b1;
        state_d  = StStream;
      end
      StStream: begin
        mem_addr = base_q + AW'(rc_q);
        if (hold_vld_q) begin
          // Held word goes out first; no read this cycle keeps order intact
          if (!fd_io.stall) begin
            ce         = 1'b1;
            act        = hold_q;
            hold_vld_d = 1'b0;
          end
        end else if (rd_q) begin
          if (!fd_io.stall) begin
            ce  = 1'b1;
            act = fd_io.mem_data;
          end else begin
            hold_vld_d = 1'b1;
            hold_d     = fd_io.mem_data;
          end
        end
        mem_rd = !fd_io.stall && !hold_vld_q && (rc_q < CW'(NN));
        rd_d   = mem_rd;
        if (mem_rd) rc_d = rc_q + CW'(1);
        if (ce) begin
          pc_d = pc_q + CW'(1);
          if (pc_q == CW'(NN - 1)) state_d = (FLUSH == 0) ? StWaitEnd : StFlush;
        end
      end
      StFlush: begin
        if (!fd_io.stall) begin
          ce   = 1'b1;
          fc_d = fc_q + FW'(1);
          if (fc_q == FW'(FLUSH - 1)) state_d = StWaitEnd;
        end
      end
      StWaitEnd: begin
        if (fd_io.end_conv) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (!fd_io.stall) begin
          ce = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q    <= StIdle;
      rc_q       <= '0;
      pc_q       <= '0;
      fc_q       <= '0;
      base_q     <= '0;
      rd_q       <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      pc_q       <= pc_d;
      fc_q       <= fc_d;
      base_q     <= base_d;
      rd_q       <= rd_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
    end
  end

  assign fd_io.mem_addr   = mem_addr;
  assign fd_io.mem_rd     = mem_rd;
  assign fd_io.conv_rst   = conv_rst;
  assign fd_io.ce_o       = ce;
  assign fd_io.activation = act;
  assign fd_io.busy       = (state_q != StIdle);
  assign fd_io.done       = done_q;

`ifdef FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of stalled busy cycles, cleared on each accepted start
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      stall_cnt_q <= '0;
    end else if (state_q == StIdle && fd_io.start && !done_q) begin
      stall_cnt_q <= '0;
    end else if (state_q != StIdle && fd_io.stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
